bju_bp: RTL and testbench

- Parametrised next-generation branch/jump unit for the 5-stage RV32I pipeline.
- Adds a direct-mapped branch target buffer (BTB) and a 2-bit bimodal history table (BHT), looked up in Fetch; branches/jumps still resolve in Decode with E/M/W forwarding.
- Decode compares the resolved outcome against the carried Fetch prediction, raises a redirect on mispredict, and trains the tables.
- Sits between the PC/fetch logic (PC_F, prediction) and the hazard unit (stall/flush, redirect).

---
 rtl/bju_pkg.sv | 21 ++
 rtl/bju_btb.sv | 67 ++++++
 rtl/bju_bp.sv | 98 +++++++++
 tb/tb_bju_bp.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bju_pkg.sv
// bju_pkg: shared encodings (branch funct3, jump type, forwarding select, BTB update op) and counter constants
package bju_pkg;
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_NB0  = 3'b010,
    BR_NB1  = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_e;
  typedef enum logic {JT_JALR = 1'b0, JT_JAL = 1'b1} jt_e;
  typedef enum logic [1:0] {FW_NONE = 2'b00, FW_E = 2'b01, FW_M = 2'b10, FW_W = 2'b11} fw_e;
  typedef enum logic [2:0] {UPD_NONE, UPD_TRAIN, UPD_ALLOC_BR, UPD_ALLOC_JAL, UPD_INVAL} upd_e;
  localparam logic [1:0] CTR_RST   = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  function automatic logic is_cond(input logic [2:0] br);
    return br[2:1] != 2'b01;
  endfunction
endpackage

// File: rtl/bju_btb.sv
// bju_btb: direct-mapped BTB + 2-bit BHT; ports: rd_pc->rd_taken/rd_target (Fetch), upd_pc->upd_hit (Decode), upd_op/upd_taken/upd_target (sync write)
module bju_btb
  import bju_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-3:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic [XLEN-3:0] upd_pc,
  output logic            upd_hit,
  input  upd_e            upd_op,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = XLEN - 2 - IDX_W;
  logic [N-1:0]      valid_q, valid_d, jal_q, jal_d;
  logic [1:0]        ctr_q [N];
  logic [1:0]        ctr_d [N];
  logic [TAG_W-1:0]  tag_q [N];
  logic [TAG_W-1:0]  tag_d [N];
  logic [XLEN-1:0]   tgt_q [N];
  logic [XLEN-1:0]   tgt_d [N];
  logic [IDX_W-1:0]  ri, ui;
  logic [1:0]        uc;
  assign ri        = rd_pc[IDX_W-1:0];
  assign ui        = upd_pc[IDX_W-1:0];
  assign rd_taken  = valid_q[ri] && tag_q[ri] == rd_pc[XLEN-3:IDX_W] && (jal_q[ri] || ctr_q[ri][1]);
  assign rd_target = tgt_q[ri];
  assign upd_hit   = valid_q[ui] && tag_q[ui] == upd_pc[XLEN-3:IDX_W];
  assign uc        = ctr_q[ui];
  always_comb begin
    valid_d = valid_q;
    jal_d   = jal_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_op == UPD_TRAIN)
      ctr_d[ui] = upd_taken ? (uc == 2'b11 ? uc : uc + 2'd1) : (uc == 2'b00 ? uc : uc - 2'd1);
    if (upd_op == UPD_ALLOC_BR || upd_op == UPD_ALLOC_JAL) begin
      valid_d[ui] = 1'b1;
      jal_d[ui]   = upd_op == UPD_ALLOC_JAL;
      tag_d[ui]   = upd_pc[XLEN-3:IDX_W];
      tgt_d[ui]   = upd_target;
    end
    if (upd_op == UPD_ALLOC_BR) ctr_d[ui] = CTR_ALLOC;
    if (upd_op == UPD_INVAL) valid_d[ui] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) ctr_q[i] <= CTR_RST;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end
  always_ff @(posedge clk) begin
    jal_q <= jal_d;
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end
endmodule

// File: rtl/bju_bp.sv
// bju_bp: predicting branch/jump unit; Fetch PC_F->pred_taken_F/pred_target_F, Decode resolve->taken_D/redirect_D/redirect_PC_D, perf counters
module bju_bp
  import bju_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  PC_F,
  output logic             pred_taken_F,
  output logic [XLEN-1:0]  pred_target_F,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             valid_D,
  input  logic [XLEN-1:0]  PC_D,
  input  logic [XLEN-1:0]  rs1_D,
  input  logic [XLEN-1:0]  rs2_D,
  input  logic [XLEN-1:0]  imm_D,
  input  logic [XLEN-1:0]  ALU_result_E,
  input  logic [XLEN-1:0]  ALU_result_M,
  input  logic [XLEN-1:0]  WB_data,
  input  logic [1:0]       forward_A_D,
  input  logic [1:0]       forward_B_D,
  input  logic [2:0]       branch,
  input  logic             jump,
  input  logic             jump_type,
  output logic             redirect_D,
  output logic [XLEN-1:0]  redirect_PC_D,
  output logic             taken_D,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  logic             hit_taken, d_hit, pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]  btb_tgt, pred_target_q, pred_target_d, fa, fb, jalr_sum, target;
  logic [CNT_W-1:0] br_count_q, br_count_d, mispred_count_q, mispred_count_d;
  logic             eq, lt, ltu, cond, cond_true, res;
  upd_e             upd_op;
  bju_btb #(.XLEN(XLEN), .IDX_W(IDX_W)) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_pc      (PC_F[XLEN-1:2]),
    .rd_taken   (hit_taken),
    .rd_target  (btb_tgt),
    .upd_pc     (PC_D[XLEN-1:2]),
    .upd_hit    (d_hit),
    .upd_op     (upd_op),
    .upd_taken  (taken_D),
    .upd_target (target)
  );
  always_comb begin
    pred_taken_F  = hit_taken;
    pred_target_F = hit_taken ? btb_tgt : PC_F + XLEN'(4);
    fa = forward_A_D == FW_E ? ALU_result_E : forward_A_D == FW_M ? ALU_result_M :
         forward_A_D == FW_W ? WB_data : rs1_D;
    fb = forward_B_D == FW_E ? ALU_result_E : forward_B_D == FW_M ? ALU_result_M :
         forward_B_D == FW_W ? WB_data : rs2_D;
    eq  = fa == fb;
    lt  = $signed(fa) < $signed(fb);
    ltu = fa < fb;
    cond = is_cond(branch);
    cond_true = branch == BR_BEQ ? eq : branch == BR_BNE ? !eq : branch == BR_BLT ? lt :
                branch == BR_BGE ? !lt : branch == BR_BLTU ? ltu : branch == BR_BGEU ? !ltu : 1'b0;
    jalr_sum = fa + imm_D;
    target   = jump && jump_type == JT_JALR ? {jalr_sum[XLEN-1:1], 1'b0} : PC_D + imm_D;
    taken_D  = valid_D && (jump || cond_true);
    // reset also blocks resolution so no redirect or table write leaks out while rst_n is low
    res = rst_n && valid_D && !stall_D;
    redirect_D    = res && (taken_D != pred_taken_q || (taken_D && target != pred_target_q));
    redirect_PC_D = taken_D ? target : PC_D + XLEN'(4);
    // JALR is deliberately never allocated; a hit on a non-control-flow instruction is an alias to evict
    upd_op = !res ? UPD_NONE :
             jump ? (jump_type == JT_JAL ? UPD_ALLOC_JAL : UPD_NONE) :
             cond ? (d_hit ? UPD_TRAIN : taken_D ? UPD_ALLOC_BR : UPD_NONE) :
             d_hit ? UPD_INVAL : UPD_NONE;
    pred_taken_d    = !flush_D && (stall_D ? pred_taken_q : pred_taken_F);
    pred_target_d   = flush_D ? '0 : stall_D ? pred_target_q : pred_target_F;
    br_count_d      = br_count_q + CNT_W'(res && (jump || cond));
    mispred_count_d = mispred_count_q + CNT_W'(redirect_D);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken_q    <= 1'b0;
      pred_target_q   <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      pred_taken_q    <= pred_taken_d;
      pred_target_q   <= pred_target_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
endmodule

// File: tb/tb_bju_bp.sv
// tb_bju_bp: scoreboard bench for bju_bp
module tb_bju_bp;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] PC_F = 32'h100, PC_D = '0, rs1_D = '0, rs2_D = '0, imm_D = '0;
  logic [31:0] ALU_result_E = 32'h2001, ALU_result_M = 32'h5, WB_data = 32'hffff_ffff;
  logic [1:0]  forward_A_D = '0, forward_B_D = '0;
  logic [2:0]  branch = 3'b010;
  logic        stall_D = 1'b0, flush_D = 1'b0, valid_D = 1'b0, jump = 1'b0, jump_type = 1'b0;
  logic        pred_taken_F, redirect_D, taken_D;
  logic [31:0] pred_target_F, redirect_PC_D, br_count, mispred_count;
  bju_bp #(.XLEN(32), .BTB_ENTRIES(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .PC_F(PC_F), .pred_taken_F(pred_taken_F), .pred_target_F(pred_target_F),
    .stall_D(stall_D), .flush_D(flush_D), .valid_D(valid_D), .PC_D(PC_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .imm_D(imm_D), .ALU_result_E(ALU_result_E), .ALU_result_M(ALU_result_M), .WB_data(WB_data),
    .forward_A_D(forward_A_D), .forward_B_D(forward_B_D), .branch(branch), .jump(jump),
    .jump_type(jump_type), .redirect_D(redirect_D), .redirect_PC_D(redirect_PC_D), .taken_D(taken_D),
    .br_count(br_count), .mispred_count(mispred_count)
  );
  always #5 clk = ~clk;
  typedef enum int {S_PT, S_PTGT, S_TK, S_RED, S_RPC, S_BR, S_MIS} sel_e;
  typedef struct {string tag; sel_e sel; logic [31:0] exp;} sb_t;
  sb_t sb[$];
  int vectors = 0, miscompares = 0, exp_br = 0, exp_mis = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] obs_of(input sel_e s);
    case (s)
      S_PT:    return {31'b0, pred_taken_F};
      S_PTGT:  return pred_target_F;
      S_TK:    return {31'b0, taken_D};
      S_RED:   return {31'b0, redirect_D};
      S_RPC:   return redirect_PC_D;
      S_BR:    return br_count;
      S_MIS:   return mispred_count;
      default: return 32'hdead_beef;
    endcase
  endfunction
  task automatic push(input string tag, input sel_e s, input logic [31:0] e);
    sb.push_back('{tag, s, e});
  endtask
  task automatic step();
    sb_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_of(e.sel), e.exp);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic lookup(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    PC_F = pc;
    valid_D = 1'b0;
    push($sformatf("lk%0h_pt", pc), S_PT, {31'b0, pt});
    push($sformatf("lk%0h_tgt", pc), S_PTGT, tgt);
    step();
  endtask
  task automatic resolve(input logic [31:0] pcf, input logic pt, input logic [31:0] pcd, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [2:0] br, input logic jmp, input logic jt, input logic stl,
                         input logic tk, input logic red, input logic [31:0] rpc);
    PC_F = pcf; valid_D = 1'b1; PC_D = pcd; imm_D = imm; rs1_D = a; rs2_D = b;
    forward_A_D = fa; forward_B_D = fb; branch = br; jump = jmp; jump_type = jt; stall_D = stl;
    push($sformatf("rs%0h_pt", pcd), S_PT, {31'b0, pt});
    push($sformatf("rs%0h_taken", pcd), S_TK, {31'b0, tk});
    push($sformatf("rs%0h_redir", pcd), S_RED, {31'b0, red});
    push($sformatf("rs%0h_rpc", pcd), S_RPC, rpc);
    if (!stl && rst_n) begin
      if (jmp || br[2:1] != 2'b01) exp_br++;
      if (red) exp_mis++;
    end
    step();
    valid_D = 1'b0; stall_D = 1'b0; jump = 1'b0; branch = 3'b010; forward_A_D = '0; forward_B_D = '0;
    push("br_count", S_BR, exp_br);
    push("mispred_count", S_MIS, exp_mis);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    push("rst_pt", S_PT, 0);
    push("rst_tgt", S_PTGT, 32'h104);
    push("rst_redir", S_RED, 0);
    push("rst_br", S_BR, 0);
    push("rst_mis", S_MIS, 0);
    step();
    rst_n = 1'b1;
    lookup(32'h100, 0, 32'h104);
    resolve(32'h100, 0, 32'h100, 32'h40, 5, 5, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h140);
    lookup(32'h100, 1, 32'h140);
    resolve(32'h104, 0, 32'h100, 32'h40, 5, 6, 0, 0, 3'd0, 0, 0, 0, 0, 1, 32'h104);
    lookup(32'h100, 0, 32'h104);
    resolve(32'h104, 0, 32'h100, 32'h40, 5, 6, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h104);
    resolve(32'h104, 0, 32'h100, 32'h40, 5, 6, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h104);
    resolve(32'h104, 0, 32'h100, 32'h40, 5, 5, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h140);
    lookup(32'h100, 0, 32'h104);
    for (int i = 0; i < 3; i++) resolve(32'h104, 0, 32'h100, 32'h40, 5, 5, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h140);
    lookup(32'h100, 1, 32'h140);
    resolve(32'h104, 0, 32'h100, 32'h40, 5, 5, 0, 0, 3'd0, 0, 0, 0, 1, 0, 32'h140);
    resolve(32'h104, 0, 32'h100, 32'h40, 5, 6, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h104);
    lookup(32'h100, 1, 32'h140);
    resolve(32'h204, 0, 32'h200, 32'h4, 32'h999, 0, 2'b01, 2'b00, 3'd2, 1, 0, 0, 1, 1, 32'h2004);
    lookup(32'h200, 0, 32'h204);
    resolve(32'h414, 0, 32'h410, 32'h10, 5, 1, 2'b11, 2'b00, 3'd4, 0, 0, 0, 1, 1, 32'h420);
    resolve(32'h414, 0, 32'h410, 32'h10, 5, 1, 2'b11, 2'b00, 3'd6, 0, 0, 0, 0, 0, 32'h414);
    resolve(32'h414, 0, 32'h410, 32'h10, 7, 0, 2'b00, 2'b10, 3'd5, 0, 0, 0, 1, 1, 32'h420);
    resolve(32'h414, 0, 32'h410, 32'h10, 3, 0, 2'b00, 2'b01, 3'd7, 0, 0, 0, 0, 0, 32'h414);
    resolve(32'h524, 0, 32'h520, 32'h100, 0, 0, 0, 0, 3'd2, 1, 1, 0, 1, 1, 32'h620);
    lookup(32'h520, 1, 32'h620);
    resolve(32'h524, 0, 32'h520, 32'h100, 0, 0, 0, 0, 3'd2, 1, 1, 0, 1, 0, 32'h620);
    lookup(32'h520, 1, 32'h620);
    resolve(32'h524, 0, 32'h520, 32'h100, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 1, 32'h524);
    lookup(32'h520, 0, 32'h524);
    lookup(32'h100, 1, 32'h140);
    resolve(32'h900, 0, 32'h730, 32'h20, 1, 2, 0, 0, 3'd1, 0, 0, 1, 1, 0, 32'h750);
    resolve(32'h730, 0, 32'h730, 32'h20, 1, 2, 0, 0, 3'd1, 0, 0, 0, 1, 1, 32'h750);
    lookup(32'h100, 1, 32'h140);
    resolve(32'h904, 0, 32'h900, 0, 0, 0, 0, 0, 3'd2, 0, 0, 1, 0, 0, 32'h904);
    resolve(32'h904, 0, 32'h900, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 1, 32'h904);
    lookup(32'h100, 1, 32'h140);
    flush_D = 1'b1;
    stall_D = 1'b1;
    lookup(32'h100, 1, 32'h140);
    flush_D = 1'b0;
    stall_D = 1'b0;
    resolve(32'h904, 0, 32'h900, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 32'h904);
    lookup(32'h100, 1, 32'h140);
    rst_n = 1'b0;
    exp_br = 0;
    exp_mis = 0;
    lookup(32'h100, 0, 32'h104);
    resolve(32'h100, 0, 32'h100, 32'h40, 5, 5, 0, 0, 3'd0, 0, 0, 0, 1, 0, 32'h140);
    rst_n = 1'b1;
    lookup(32'h100, 0, 32'h104);
    lookup(32'h410, 0, 32'h414);
    lookup(32'h730, 0, 32'h734);
    resolve(32'h104, 0, 32'h100, 32'h40, 5, 5, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h140);
    lookup(32'h100, 1, 32'h140);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
